run_ctrl_monitor: RTL and testbench
===================================

# run_ctrl_monitor

Synthesizable run controller and state-dump engine for the `cpu` top. It starts a program run and counts cycles. It detects the end-of-program instruction word on the fetch stage, or a cycle timeout. After a parametrised drain window it freezes the core. It then streams the register file and a window of unified-memory words out over a valid/ready port, so bring-up runs on FPGA produce the same end-of-run dump as simulation.

## Interface
- XLEN, 32, data width
- REG_NUM, 32, registers dumped
- ADDR_SIZE, 5, regfile address width
- PC_BITS, 20, PC width
- END_INST, 32'h00000000, instruction word that marks end of program
- DRAIN_CYCLES, 5, cycles run after end match before freeze (0 allowed)
- TIMEOUT_CYCLES, 2000, run aborts once the cycle count exceeds this
- CNT_BITS, 32, cycle counter width
- MEM_BASE_LINE, 0, first memory line dumped
- MEM_LINES, 24, memory lines dumped
- LINE_WORDS, 4, words per line (power of two)
- LINE_BITS, 5, memory line address width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin run; honoured in IDLE and DONE only
- f_inst  in  32  fetch-stage instruction
- f_valid  in  1  f_inst is a real fetch (not stalled/bubble)
- f_pc  in  PC_BITS  fetch-stage PC
- cpu_run  out  1  core enable; 0 freezes pipeline
- rf_raddr  out  ADDR_SIZE  debug regfile read address (combinational read)
- rf_rdata  in  XLEN  regfile data for rf_raddr
- mem_line  out  LINE_BITS  debug memory line address (combinational read)
- mem_word  out  log2(LINE_WORDS)  word within line
- mem_rdata  in  XLEN  memory data
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  sink accepts beat
- dump_is_mem  out  1  0 = register beat, 1 = memory beat
- dump_index  out  16  register number, or linear word index from MEM_BASE_LINE
- dump_data  out  XLEN  beat payload
- cycles  out  CNT_BITS  run cycle count; frozen at end match/timeout
- end_pc  out  PC_BITS  f_pc captured at end match
- busy  out  1  state is not IDLE and not DONE
- done  out  1  level; high in DONE
- timeout  out  1  level; set when run ended by timeout

## Operation
- States: IDLE, RUN, DRAIN, DUMP_REG, DUMP_MEM, DONE.
- IDLE: cpu_run=0. start -> RUN; cycles, end_pc, timeout cleared.
- RUN: cpu_run=1. cycles increments every clock, so the first RUN cycle makes it 1.
  - End match = f_valid && f_inst==END_INST. On match, end_pc<=f_pc and cycles freezes at its value including this cycle.
  - After an end match: DRAIN_CYCLES>0 -> DRAIN, otherwise -> DUMP_REG.
  - Matching f_inst with f_valid=0 is ignored.
  - If the incremented count would exceed TIMEOUT_CYCLES: timeout<=1, cycles stops at TIMEOUT_CYCLES+1, drain is skipped -> DUMP_REG.
  - End match and timeout in the same cycle: end match wins and timeout stays 0.
  - Counter saturates; it never wraps.
- DRAIN: cpu_run=1 for exactly DRAIN_CYCLES clocks, then -> DUMP_REG. cycles stays frozen.
- DUMP_REG: cpu_run=0. Beats cover registers 0..REG_NUM-1.
- DUMP_MEM: cpu_run=0. Beats cover lines MEM_BASE_LINE..+MEM_LINES-1. Word order is 0..LINE_WORDS-1 within each line; dump_index runs 0..MEM_LINES*LINE_WORDS-1.
  - MEM_LINES=0: DUMP_MEM is skipped.
- Handshake:
  - dump_data, dump_index and dump_is_mem are registered, sampled from the combinational read ports.
  - A beat transfers when dump_valid && dump_ready.
  - While dump_valid && !dump_ready, all dump outputs hold stable.
  - After the last beat transfers -> DONE.
- DONE: cpu_run=0, done=1. start -> RUN, a new run that clears counters. Memory and regs are not touched.
- start outside IDLE/DONE is ignored.

## Timing
- Reset values: state IDLE; cpu_run=0, dump_valid=0, dump_is_mem=0, dump_index=0, dump_data=0, rf_raddr=0, mem_line=MEM_BASE_LINE, mem_word=0, cycles=0, end_pc=0, busy=0, done=0, timeout=0.
- start sampled at cycle t -> cpu_run=1 and busy=1 from t+1.
- End match at cycle t:
  - cycles/end_pc visible at t+1.
  - cpu_run falls at t+1+DRAIN_CYCLES.
- First dump_valid rises one clock after entering DUMP_REG, the read-address setup cycle.
- With dump_ready held high, one beat per clock; the DUMP_REG->DUMP_MEM transition adds no bubble.
- done rises the clock after the last beat transfer.
- rst high on any edge, including mid-drain or mid-dump, returns every output to its reset value on the next clock; a partial dump is abandoned.

## Test plan
- Program with END_INST fetched valid at RUN cycle 7, DRAIN_CYCLES=5, dump_ready=1 -> cycles=7, end_pc=captured PC, cpu_run low 5 clocks later, 32 reg beats then 96 mem beats, done=1, timeout=0.
- Infinite loop, TIMEOUT_CYCLES=20 -> timeout=1, cycles=21, no drain, full dump, done=1.
- END_INST on f_inst with f_valid=0 at cycle 3, valid match at cycle 9 -> cycles=9.
- Random dump_ready backpressure -> every beat delivered once, in order, payload stable while stalled; regfile x5=0x1234 appears at dump_index 5.
- End match on the same cycle the timeout is reached (TIMEOUT_CYCLES=10, match at cycle 11) -> timeout=0, cycles=11.
- rst asserted mid-DUMP_MEM, then start -> all outputs at reset values, then a clean new run with dump_index restarting at 0.

Source files
------------

// File: rtl/run_ctrl_monitor.sv
// Run controller: starts the core, detects end of program or timeout,
// drains, freezes, then streams regfile and memory words out.
module run_ctrl_monitor #(
    parameter int          XLEN           = 32,
    parameter int          REG_NUM        = 32,
    parameter int          ADDR_SIZE      = 5,
    parameter int          PC_BITS        = 20,
    parameter logic [31:0] END_INST       = 32'h00000000,
    parameter int          DRAIN_CYCLES   = 5,
    parameter int          TIMEOUT_CYCLES = 2000,
    parameter int          CNT_BITS       = 32,
    parameter int          MEM_BASE_LINE  = 0,
    parameter int          MEM_LINES      = 24,
    parameter int          LINE_WORDS     = 4,
    parameter int          LINE_BITS      = 5,
    localparam int         WORD_BITS      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          f_inst,
    input  logic                 f_valid,
    input  logic [PC_BITS-1:0]   f_pc,
    output logic                 cpu_run,
    output logic [ADDR_SIZE-1:0] rf_raddr,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic [LINE_BITS-1:0] mem_line,
    output logic [WORD_BITS-1:0] mem_word,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic                 dump_is_mem,
    output logic [15:0]          dump_index,
    output logic [XLEN-1:0]      dump_data,
    output logic [CNT_BITS-1:0]  cycles,
    output logic [PC_BITS-1:0]   end_pc,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int MEM_BEATS = MEM_LINES * LINE_WORDS;
    localparam int DCNT_BITS = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DUMP_REG, S_DUMP_MEM, S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic                 match, over, load, xfer;
    logic                 last_reg, last_mem;
    logic                 rd_pend, rd_mem;
    logic [15:0]          mem_idx;
    logic [CNT_BITS-1:0]  cnt_inc;
    logic [DCNT_BITS-1:0] dcnt;

    assign match    = f_valid && (f_inst == END_INST);
    assign cnt_inc  = (cycles == '1) ? cycles : cycles + 1'b1;
    assign over     = cnt_inc > CNT_BITS'(TIMEOUT_CYCLES);
    assign load     = !dump_valid || dump_ready;
    assign xfer     = dump_valid && dump_ready;
    assign last_reg = rf_raddr == ADDR_SIZE'(REG_NUM - 1);
    assign last_mem = mem_idx == 16'(MEM_BEATS - 1);

    always_comb begin
        state_nxt = state;
        cpu_run   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                if (match)
                    state_nxt = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DUMP_REG;
                else if (over)
                    state_nxt = S_DUMP_REG;
            end
            S_DRAIN: begin
                cpu_run = 1'b1;
                if (dcnt == DCNT_BITS'(DRAIN_CYCLES - 1))
                    state_nxt = S_DUMP_REG;
            end
            S_DUMP_REG, S_DUMP_MEM: begin
                if (state == S_DUMP_REG && load && rd_pend && rd_mem == 1'b0
                    && last_reg && MEM_LINES > 0)
                    state_nxt = S_DUMP_MEM;
                else if (xfer && !rd_pend)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_raddr    <= '0;
            mem_line    <= LINE_BITS'(MEM_BASE_LINE);
            mem_word    <= '0;
            mem_idx     <= '0;
            rd_pend     <= 1'b0;
            rd_mem      <= 1'b0;
            dcnt        <= '0;
            dump_valid  <= 1'b0;
            dump_is_mem <= 1'b0;
            dump_index  <= '0;
            dump_data   <= '0;
            cycles      <= '0;
            end_pc      <= '0;
            timeout     <= 1'b0;
        end else begin
            // Arm the read pointer so the first beat is sampled next clock
            if (state_nxt == S_DUMP_REG && state != S_DUMP_REG) begin
                rf_raddr <= '0;
                rd_mem   <= 1'b0;
                rd_pend  <= 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cycles  <= '0;
                        end_pc  <= '0;
                        timeout <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycles <= cnt_inc;
                    dcnt   <= '0;
                    if (match)     end_pc  <= f_pc;
                    else if (over) timeout <= 1'b1;
                end
                S_DRAIN: dcnt <= dcnt + 1'b1;
                S_DUMP_REG, S_DUMP_MEM: begin
                    if (load && rd_pend) begin
                        dump_valid  <= 1'b1;
                        dump_is_mem <= rd_mem;
                        dump_data   <= rd_mem ? mem_rdata : rf_rdata;
                        dump_index  <= rd_mem ? mem_idx : 16'(rf_raddr);
                        if (!rd_mem) begin
                            if (!last_reg) begin
                                rf_raddr <= rf_raddr + 1'b1;
                            end else if (MEM_LINES > 0) begin
                                rd_mem   <= 1'b1;
                                mem_line <= LINE_BITS'(MEM_BASE_LINE);
                                mem_word <= '0;
                                mem_idx  <= '0;
                            end else begin
                                rd_pend <= 1'b0;
                            end
                        end else if (last_mem) begin
                            rd_pend <= 1'b0;
                        end else begin
                            mem_idx <= mem_idx + 1'b1;
                            if (mem_word == WORD_BITS'(LINE_WORDS - 1)) begin
                                mem_word <= '0;
                                mem_line <= mem_line + 1'b1;
                            end else begin
                                mem_word <= mem_word + 1'b1;
                            end
                        end
                    end else if (xfer) begin
                        dump_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl_monitor.sv
// Randomised bench for run_ctrl_monitor with a beat-list reference model.
module tb_run_ctrl_monitor;

    localparam int          REG_NUM = 32;
    localparam int          DRAIN   = 5;
    localparam int          TO      = 20;
    localparam int          BASE    = 3;
    localparam int          LINES   = 24;
    localparam int          LW      = 4;
    localparam int          BEATS   = REG_NUM + LINES * LW;
    localparam logic [31:0] END_I   = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] f_inst = 32'hffff_ffff;
    logic        f_valid = 1'b0;
    logic [19:0] f_pc = '0;
    logic        cpu_run;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [4:0]  mem_line;
    logic [1:0]  mem_word;
    logic [31:0] mem_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic        dump_is_mem;
    logic [15:0] dump_index;
    logic [31:0] dump_data;
    logic [31:0] cycles;
    logic [19:0] end_pc;
    logic        busy, done, timeout;

    logic [31:0] regs [REG_NUM];
    logic [31:0] mem  [128];

    int checks = 0;
    int errors = 0;

    bit          rq_mem [$];
    int          rq_idx [$];
    logic [31:0] rq_data[$];

    assign rf_rdata  = regs[rf_raddr];
    assign mem_rdata = mem[{mem_line, mem_word}];

    always #5 clk = ~clk;

    run_ctrl_monitor #(
        .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TO), .MEM_BASE_LINE(BASE),
        .MEM_LINES(LINES), .LINE_WORDS(LW), .LINE_BITS(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .f_inst(f_inst), .f_valid(f_valid), .f_pc(f_pc),
        .cpu_run(cpu_run), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_line(mem_line), .mem_word(mem_word), .mem_rdata(mem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_is_mem(dump_is_mem), .dump_index(dump_index),
        .dump_data(dump_data), .cycles(cycles), .end_pc(end_pc),
        .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic fill_storage();
        for (int i = 0; i < REG_NUM; i++) regs[i] = $urandom;
        regs[5] = 32'h1234;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
    endtask

    task automatic test_reset(input string tag);
        logic [117:0] got, exp;
        rst = 1'b1;
        start = 1'b0;
        dump_ready = 1'b0;
        f_valid = 1'b0;
        @(posedge clk); #1;
        got = {cpu_run, dump_valid, dump_is_mem, dump_index, dump_data,
               rf_raddr, mem_line, mem_word, cycles, end_pc,
               busy, done, timeout};
        exp = {1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 5'd0, 5'(BASE), 2'd0,
               32'd0, 20'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_%s outputs got %h expected %h", tag, got, exp);
        end
        rst = 1'b0;
    endtask

    task automatic collect(input string tag, input bit bp, input int stop_after);
        int n = 0;
        int last_xfer = -10;
        int gaps = 0;
        int stall_bad = 0;
        int bad = -1;
        bit finished = 1'b0;
        bit seen = 1'b0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [49:0] prev = '0;
        bit em;
        int ei;
        logic [31:0] ed;
        rq_mem.delete();
        rq_idx.delete();
        rq_data.delete();
        while (n < 3000) begin
            @(posedge clk); #1;
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (n == 0) begin
                checks++;
                if (dump_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s first_valid got %b expected 1", tag, dump_valid);
                end
            end
            if (pv && !pr && {dump_valid, dump_is_mem, dump_index, dump_data} !== prev)
                stall_bad++;
            if (seen && !dump_valid) gaps++;
            if (dump_valid) seen = 1'b1;
            dump_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (dump_valid && dump_ready) begin
                rq_mem.push_back(dump_is_mem);
                rq_idx.push_back(int'(dump_index));
                rq_data.push_back(dump_data);
                last_xfer = n;
            end
            pv = dump_valid;
            pr = dump_ready;
            prev = {dump_valid, dump_is_mem, dump_index, dump_data};
            if (stop_after > 0 && rq_idx.size() >= stop_after) return;
            n++;
        end
        checks++;
        if (!finished || last_xfer != n - 1) begin
            errors++;
            $display("FAIL %s done_timing done=%b last_xfer=%0d done_at=%0d expected done at last_xfer+1",
                     tag, finished, last_xfer, n);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall_hold changed %0d times expected 0", tag, stall_bad);
        end
        if (!bp) begin
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL %s bubbles got %0d expected 0", tag, gaps);
            end
        end
        checks++;
        if (rq_idx.size() != BEATS) begin
            errors++;
            $display("FAIL %s beat_count got %0d expected %0d", tag, rq_idx.size(), BEATS);
        end
        for (int j = 0; j < rq_idx.size() && j < BEATS; j++) begin
            em = (j >= REG_NUM);
            ei = em ? j - REG_NUM : j;
            ed = em ? mem[(BASE + ei / LW) * LW + ei % LW] : regs[j];
            if (bad < 0 && (rq_mem[j] !== em || rq_idx[j] != ei || rq_data[j] !== ed)) begin
                bad = j;
                $display("FAIL %s beat%0d got mem=%b idx=%0d data=%h expected mem=%b idx=%0d data=%h",
                         tag, j, rq_mem[j], rq_idx[j], rq_data[j], em, ei, ed);
            end
        end
        checks++;
        if (bad >= 0) errors++;
        if (rq_idx.size() > 5) begin
            checks++;
            if (rq_idx[5] != 5 || rq_data[5] !== 32'h1234) begin
                errors++;
                $display("FAIL %s x5_beat got idx=%0d data=%h expected idx=5 data=00001234",
                         tag, rq_idx[5], rq_data[5]);
            end
        end
    endtask

    task automatic do_run(input string tag, input int match_k, input int ghost_k,
                          input bit bp, input int stop_after);
        bit          hit = (match_k > 0) && (match_k <= TO + 1);
        int          exp_end = hit ? match_k : TO + 1;
        bit          exp_to = !hit;
        logic [19:0] exp_pc = '0;
        int          run_bad = 0;
        int          drain_bad = 0;
        fill_storage();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({cpu_run, busy, done, timeout, cycles, end_pc} !== {4'b1100, 32'd0, 20'd0}) begin
            errors++;
            $display("FAIL %s start run=%b busy=%b done=%b to=%b cyc=%0d pc=%h expected 1 1 0 0 0 0",
                     tag, cpu_run, busy, done, timeout, cycles, end_pc);
        end
        for (int k = 1; k <= exp_end; k++) begin
            f_pc = 20'($urandom);
            f_valid = ($urandom_range(0, 3) != 0);
            f_inst = $urandom | 32'h1;
            if (k == match_k) begin
                f_valid = 1'b1;
                f_inst = END_I;
                exp_pc = f_pc;
            end else if (k == ghost_k) begin
                f_valid = 1'b0;
                f_inst = END_I;
            end
            @(posedge clk); #1;
            if (k < exp_end && (cycles !== 32'(k) || cpu_run !== 1'b1)) run_bad++;
        end
        f_valid = 1'b0;
        f_inst = 32'hffff_ffff;
        checks++;
        if (run_bad != 0) begin
            errors++;
            $display("FAIL %s run_count %0d bad cycles expected 0", tag, run_bad);
        end
        checks++;
        if (cycles !== 32'(exp_end) || end_pc !== exp_pc || timeout !== exp_to) begin
            errors++;
            $display("FAIL %s end cyc=%0d pc=%h to=%b expected cyc=%0d pc=%h to=%b",
                     tag, cycles, end_pc, timeout, exp_end, exp_pc, exp_to);
        end
        checks++;
        if (cpu_run !== !exp_to) begin
            errors++;
            $display("FAIL %s run_after_end got %b expected %b", tag, cpu_run, !exp_to);
        end
        if (!exp_to) begin
            for (int d = 1; d <= DRAIN; d++) begin
                start = (d == 2);
                @(posedge clk); #1;
                if (d < DRAIN && cpu_run !== 1'b1) drain_bad++;
            end
            start = 1'b0;
        end
        checks++;
        if (drain_bad != 0 || cpu_run !== 1'b0 || busy !== 1'b1 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s freeze drain_bad=%0d run=%b busy=%b valid=%b expected 0 0 1 0",
                     tag, drain_bad, cpu_run, busy, dump_valid);
        end
        collect(tag, bp, stop_after);
        if (stop_after == 0) begin
            checks++;
            if ({done, busy, cpu_run, dump_valid, timeout} !== {4'b1000, exp_to}
                || cycles !== 32'(exp_end)) begin
                errors++;
                $display("FAIL %s final done=%b busy=%b run=%b valid=%b to=%b cyc=%0d expected 1 0 0 0 %b %0d",
                         tag, done, busy, cpu_run, dump_valid, timeout, cycles, exp_to, exp_end);
            end
        end
    endtask

    task automatic test_end_match();
        do_run("end_match", 7, 0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        do_run("timeout", 0, 0, 1'b0, 0);
    endtask

    task automatic test_ghost_match();
        do_run("ghost", 9, 3, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        do_run("backpressure", 12, 0, 1'b1, 0);
    endtask

    task automatic test_match_at_timeout();
        do_run("match_at_timeout", TO + 1, 0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_dump();
        do_run("mid_dump", 5, 0, 1'b1, 50);
        checks++;
        if (dump_is_mem !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_dump in_mem got is_mem=%b busy=%b expected 1 1", dump_is_mem, busy);
        end
        test_reset("mid_dump");
        do_run("after_reset", 6, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset("power_on");
        test_end_match();
        test_timeout();
        test_ghost_match();
        test_backpressure();
        test_match_at_timeout();
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
